anim_sprite_src: RTL and testbench
==================================

// Module: anim_sprite_src
// PURPOSE
//  Parametrised animated sprite pixel source for the video pipeline.
//  Holds NUM_FRAMES frames of H_SIZE x V_SIZE pixels.
//  Plays the frames back under a frame-rate sequencer.
//  Supports X/Y mirroring and 2x scaling.
//  Emits chroma-keyed RGB for the current (x,y) scan position to the downstream blender.
//  Control and origin are double-buffered and take effect only at frame_start (tear-free).
// PARAMETERS
//  CD         12  colour depth (bits per pixel)
//  LOG_H      6   log2 of H_SIZE (sprite width, pixels)
//  LOG_V      6   log2 of V_SIZE (sprite height, pixels)
//  NUM_FRAMES 4   animation frames (>=1); FB = $clog2(NUM_FRAMES), min 1
//  KEY_COLOR  0   chroma key emitted when transparent or out of region
//  ADDR       FB+LOG_V+LOG_H (derived localparam); RAM address = {frame, row, col}
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous reset, active-low
//  x, y        in   11     current scan coordinate
//  x0, y0      in   11     sprite origin (sampled at frame_start)
//  frame_start in   1      1-cycle pulse at start of each video frame
//  we          in   1      sprite RAM write enable
//  addr_w      in   ADDR   sprite RAM write address
//  pixel_in    in   CD     sprite RAM write data
//  ctrl_we     in   1      control shadow-register write enable
//  ctrl_in     in   16     [1:0] mode, [2] mirror_x, [3] mirror_y, [4] scale2x,
//                          [5] enable, [9:6] rate; [15:10] ignored
//  sprite_rgb  out  CD     keyed pixel output
//  cur_frame   out  FB     frame index currently displayed
//  done        out  1      1-cycle pulse when ONESHOT reaches its last frame
// BEHAVIOUR
//  Reset (async, reset=0):
//   - shadow/active ctrl=0 (disabled, STOP); origin=0; cur_frame=0; rate_cnt=0
//   - FSM=IDLE; done=0; sprite_rgb=KEY_COLOR; pipeline regs cleared
//  ctrl_we writes the shadow register only.
//  On frame_start: active<=shadow and x0/y0 latched.
//   - ctrl_we and frame_start in the same cycle: active takes the OLD shadow;
//     the new value is applied at the next frame_start.
//  Mode change at apply: cur_frame<=0, rate_cnt<=0, FSM re-entered from IDLE.
//  Mode encoding: 0 STOP, 1 LOOP, 2 ONESHOT, 3 PINGPONG.
//  FSM states: IDLE, FWD, REV, HOLD. Evaluated only on frame_start, and only with enable=1.
//   - IDLE -> FWD (mode != STOP); STOP stays IDLE with frame frozen.
//   - Step when rate_cnt==rate: advance the frame and clear rate_cnt; otherwise rate_cnt+1.
//     So one step occurs every rate+1 frames.
//   - LOOP: frame NUM_FRAMES-1 -> 0.
//   - ONESHOT: stepping onto the last frame -> HOLD, with done pulsed the same cycle.
//     HOLD is left only by a mode change or reset.
//   - PINGPONG: FWD at last frame -> REV (frame-1); REV at frame 0 -> FWD (frame+1).
//   - NUM_FRAMES==1: frame stays 0; ONESHOT enters HOLD and pulses done on its first step.
//   - enable=0: sequencer frozen and output fully transparent.
//  Pixel pipeline, latency exactly 2 clk from x,y to sprite_rgb:
//   - S0: xr=x-x0, yr=y-y0 as 12-bit signed. s=scale2x.
//     in_region = 0<=xr<(H_SIZE<<s) && 0<=yr<(V_SIZE<<s).
//     xs=xr>>s, ys=yr>>s. col = mirror_x ? H_SIZE-1-xs : xs (row likewise with mirror_y).
//     RAM read address {cur_frame,row,col}; in_region&enable registered alongside.
//   - S1: synchronous RAM read.
//   - S2: sprite_rgb <= (region_d && enable) ? ram_dout : KEY_COLOR.
//  Read/write collision (same address, same cycle): read returns old data (read-first).
//  cur_frame change at frame_start is seen by the pipeline from the next cycle; no mid-line swap.
// STRUCTURE
//  Package sprite_pkg holds:
//   - anim_mode_t enum (STOP, LOOP, ONESHOT, PINGPONG)
//   - anim_state_t enum (IDLE, FWD, REV, HOLD)
//   - ctrl bit-position localparams
//  Sub-module sprite_ram_sync: simple dual-port RAM, 1 write port, synchronous read-first read port,
//  params ADDR_WIDTH/DATA_WIDTH.
//  Sequencer FSM and pixel pipeline live in this module.
// TESTING
//  1. Reset released with x=y=0, x0=y0=0, enable=0 -> sprite_rgb=KEY_COLOR, cur_frame=0.
//  2. RAM loaded with pixel=addr; ctrl enable=1, STOP; frame_start; x0=100, y0=50; scan x=103, y=52
//     -> sprite_rgb=frame0[2][3] two clocks later. x=164 -> KEY_COLOR.
//  3. mirror_x=1, scale2x=1, origin 0; scan x=5, y=0 -> pixel at col 61, row 0.
//     x=127 -> col 0. x=128 -> KEY_COLOR.
//  4. LOOP, rate=1, NUM_FRAMES=4; 10 frame_start pulses -> cur_frame 0,0,1,1,2,2,3,3,0,0.
//  5. ONESHOT, rate=0 -> frames 1,2,3 then HOLD at 3; done pulses exactly once.
//     PINGPONG, rate=0 -> 1,2,3,2,1,0,1.
//  6. ctrl_we and frame_start in the same cycle -> old ctrl applied, new at the next frame_start.
//     Assert reset mid-run -> all outputs reset immediately.

Source files
------------

// File: rtl/anim_sprite_src_pkg.sv
// rtl/anim_sprite_src_pkg.sv - shared types and control-word layout for the animated sprite source
// Mode/state enums plus the bit positions of the 16-bit control word.
package sprite_pkg;

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    LOOP     = 2'd1,
    ONESHOT  = 2'd2,
    PINGPONG = 2'd3
  } anim_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    HOLD = 2'd3
  } anim_state_t;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MIRROR_X = 2;
  localparam int CTRL_MIRROR_Y = 3;
  localparam int CTRL_SCALE2X  = 4;
  localparam int CTRL_ENABLE   = 5;
  localparam int CTRL_RATE_LSB = 6;
  localparam int CTRL_RATE_W   = 4;
  localparam int CTRL_W        = 10;

  typedef struct packed {
    logic [CTRL_RATE_W-1:0] rate;
    logic                   enable;
    logic                   scale2x;
    logic                   mirror_y;
    logic                   mirror_x;
    anim_mode_t             mode;
  } ctrl_t;

  function automatic ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] raw);
    ctrl_t c;
    c.mode     = anim_mode_t'(raw[CTRL_MODE_LSB +: 2]);
    c.mirror_x = raw[CTRL_MIRROR_X];
    c.mirror_y = raw[CTRL_MIRROR_Y];
    c.scale2x  = raw[CTRL_SCALE2X];
    c.enable   = raw[CTRL_ENABLE];
    c.rate     = raw[CTRL_RATE_LSB +: CTRL_RATE_W];
    return c;
  endfunction

endpackage

// File: rtl/anim_sprite_src_if.sv
// rtl/anim_sprite_src_if.sv - scan, RAM-load, control and pixel-out signals of the sprite source
// master drives scan position, RAM writes and control; slave is the sprite source.
interface anim_sprite_src_if #(
  parameter int CD         = 12,
  parameter int LOG_H      = 6,
  parameter int LOG_V      = 6,
  parameter int NUM_FRAMES = 4
);
  localparam int FB   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int ADDR = FB + LOG_V + LOG_H;

  logic [10:0]     x;
  logic [10:0]     y;
  logic [10:0]     x0;
  logic [10:0]     y0;
  logic            frame_start;
  logic            we;
  logic [ADDR-1:0] addr_w;
  logic [CD-1:0]   pixel_in;
  logic            ctrl_we;
  logic [15:0]     ctrl_in;
  logic [CD-1:0]   sprite_rgb;
  logic [FB-1:0]   cur_frame;
  logic            done;

  modport master (
    output x, y, x0, y0, frame_start, we, addr_w, pixel_in, ctrl_we, ctrl_in,
    input  sprite_rgb, cur_frame, done
  );

  modport slave (
    input  x, y, x0, y0, frame_start, we, addr_w, pixel_in, ctrl_we, ctrl_in,
    output sprite_rgb, cur_frame, done
  );

endinterface

// File: rtl/sprite_ram_sync.sv
// rtl/sprite_ram_sync.sv - simple dual-port sprite RAM, synchronous read-first read port
// A same-address write and read in one cycle returns the previous contents.
module sprite_ram_sync #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/anim_sprite_src.sv
// rtl/anim_sprite_src.sv - animated sprite pixel source: frame sequencer plus 2-cycle keyed pixel pipeline
// Control and origin are double-buffered and only become active on frame_start.
module anim_sprite_src
  import sprite_pkg::*;
#(
  parameter int            CD         = 12,
  parameter int            LOG_H      = 6,
  parameter int            LOG_V      = 6,
  parameter int            NUM_FRAMES = 4,
  parameter logic [CD-1:0] KEY_COLOR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  anim_sprite_src_if.slave  sif
);

  localparam int            FB     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int            ADDR   = FB + LOG_V + LOG_H;
  localparam int            H_SIZE = 1 << LOG_H;
  localparam int            V_SIZE = 1 << LOG_V;
  localparam logic [FB-1:0] LAST   = FB'(NUM_FRAMES - 1);

  ctrl_t                  r_shadow;
  anim_mode_t             r_mode;
  logic                   r_mirror_x;
  logic                   r_mirror_y;
  logic                   r_scale2x;
  logic                   r_enable;
  logic [10:0]            r_x0;
  logic [10:0]            r_y0;
  logic [FB-1:0]          r_cur_frame;
  logic [CTRL_RATE_W-1:0] r_rate_cnt;
  anim_state_t            r_state;
  logic                   r_done;
  logic                   r_region_d;
  logic [CD-1:0]          r_rgb;

  logic [FB-1:0]          w_inc;
  logic [FB-1:0]          w_dec;
  logic [FB-1:0]          w_step_frame;
  anim_state_t            w_step_state;
  logic                   w_step_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (sif.ctrl_we) begin
      r_shadow <= unpack_ctrl(sif.ctrl_in[CTRL_W-1:0]);
    end
  end

  assign w_inc = r_cur_frame + 1'b1;
  assign w_dec = r_cur_frame - 1'b1;

  // Frame reached by one sequencer step under the control word being applied.
  always_comb begin
    w_step_frame = r_cur_frame;
    w_step_state = r_state;
    w_step_done  = 1'b0;
    case (r_shadow.mode)
      LOOP: begin
        w_step_frame = (r_cur_frame == LAST) ? '0 : w_inc;
      end
      ONESHOT: begin
        w_step_frame = (r_cur_frame == LAST) ? r_cur_frame : w_inc;
        if ((r_cur_frame == LAST) || (w_inc == LAST)) begin
          w_step_state = HOLD;
          w_step_done  = 1'b1;
        end
      end
      PINGPONG: begin
        if (r_state == FWD) begin
          if (r_cur_frame == LAST) begin
            w_step_frame = (NUM_FRAMES > 1) ? w_dec : r_cur_frame;
            w_step_state = REV;
          end else begin
            w_step_frame = w_inc;
          end
        end else begin
          if (r_cur_frame == '0) begin
            w_step_frame = (NUM_FRAMES > 1) ? w_inc : r_cur_frame;
            w_step_state = FWD;
          end else begin
            w_step_frame = w_dec;
          end
        end
      end
      default: begin
        w_step_frame = r_cur_frame;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode      <= STOP;
      r_mirror_x  <= 1'b0;
      r_mirror_y  <= 1'b0;
      r_scale2x   <= 1'b0;
      r_enable    <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_cur_frame <= '0;
      r_rate_cnt  <= '0;
      r_state     <= IDLE;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (sif.frame_start) begin
        r_mode     <= r_shadow.mode;
        r_mirror_x <= r_shadow.mirror_x;
        r_mirror_y <= r_shadow.mirror_y;
        r_scale2x  <= r_shadow.scale2x;
        r_enable   <= r_shadow.enable;
        r_x0       <= sif.x0;
        r_y0       <= sif.y0;
        if (r_shadow.mode != r_mode) begin
          r_cur_frame <= '0;
          r_rate_cnt  <= '0;
          r_state     <= IDLE;
        end else if (r_shadow.enable) begin
          case (r_state)
            IDLE: begin
              if (r_shadow.mode != STOP) begin
                r_state <= FWD;
              end
            end
            FWD, REV: begin
              if (r_rate_cnt != r_shadow.rate) begin
                r_rate_cnt <= r_rate_cnt + 1'b1;
              end else begin
                r_rate_cnt  <= '0;
                r_cur_frame <= w_step_frame;
                r_state     <= w_step_state;
                r_done      <= w_step_done;
              end
            end
            default: begin
              r_state <= HOLD;
            end
          endcase
        end
      end
    end
  end

  logic [11:0]       w_xr;
  logic [11:0]       w_yr;
  logic [11:0]       w_xlim;
  logic [11:0]       w_ylim;
  logic              w_in_region;
  logic [LOG_H-1:0]  w_xs;
  logic [LOG_V-1:0]  w_ys;
  logic [LOG_H-1:0]  w_col;
  logic [LOG_V-1:0]  w_row;
  logic [ADDR-1:0]   w_raddr;
  logic [CD-1:0]     w_rdata;

  // Bit 11 of the 12-bit difference is the sign: negative means left of / above the origin.
  assign w_xr   = {1'b0, sif.x} - {1'b0, r_x0};
  assign w_yr   = {1'b0, sif.y} - {1'b0, r_y0};
  assign w_xlim = r_scale2x ? 12'(2 * H_SIZE) : 12'(H_SIZE);
  assign w_ylim = r_scale2x ? 12'(2 * V_SIZE) : 12'(V_SIZE);

  assign w_in_region = !w_xr[11] && (w_xr < w_xlim) && !w_yr[11] && (w_yr < w_ylim);

  assign w_xs = r_scale2x ? w_xr[LOG_H:1] : w_xr[LOG_H-1:0];
  assign w_ys = r_scale2x ? w_yr[LOG_V:1] : w_yr[LOG_V-1:0];

  // SIZE-1-n on a power-of-two range is the bitwise complement.
  assign w_col   = r_mirror_x ? ~w_xs : w_xs;
  assign w_row   = r_mirror_y ? ~w_ys : w_ys;
  assign w_raddr = {r_cur_frame, w_row, w_col};

  sprite_ram_sync #(
    .ADDR_WIDTH (ADDR),
    .DATA_WIDTH (CD)
  ) u_ram (
    .clk     (clk),
    .i_we    (sif.we),
    .i_waddr (sif.addr_w),
    .i_wdata (sif.pixel_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_region_d <= 1'b0;
      r_rgb      <= KEY_COLOR;
    end else begin
      r_region_d <= w_in_region && r_enable;
      r_rgb      <= (r_region_d && r_enable) ? w_rdata : KEY_COLOR;
    end
  end

  assign sif.sprite_rgb = r_rgb;
  assign sif.cur_frame  = r_cur_frame;
  assign sif.done       = r_done;

endmodule

// File: tb/tb_anim_sprite_src.sv
// tb/tb_anim_sprite_src.sv - directed scoreboard bench for anim_sprite_src
// Expected pixels are queued at drive time and popped when the pipeline output is due.
module tb_anim_sprite_src;
  import sprite_pkg::*;

  localparam int            CD   = 12;
  localparam int            LH   = 6;
  localparam int            LV   = 6;
  localparam int            NF   = 4;
  localparam int            ADDR = 14;
  localparam logic [CD-1:0] KEY  = 12'h000;

  logic clk;
  logic reset;

  anim_sprite_src_if #(.CD(CD), .LOG_H(LH), .LOG_V(LV), .NUM_FRAMES(NF)) sif ();

  anim_sprite_src #(
    .CD(CD), .LOG_H(LH), .LOG_V(LV), .NUM_FRAMES(NF), .KEY_COLOR(KEY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  logic [CD-1:0] exp_q[$];
  logic [CD-1:0] mem [0:(1<<ADDR)-1];

  always @(negedge clk) if (sif.done === 1'b1) done_cnt++;

  function automatic logic [CD-1:0] pix(input logic [ADDR-1:0] a);
    return a[CD-1:0] ^ {a[ADDR-1:ADDR-2], 10'h2A5};
  endfunction

  function automatic logic [ADDR-1:0] idx(input int f, input int r, input int c);
    return {2'(f), 6'(r), 6'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [CD-1:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (sif.sprite_rgb === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, sif.sprite_rgb, e);
    end
  endtask

  task automatic scan(input string tag, input logic [10:0] xx, input logic [10:0] yy,
                      input logic [CD-1:0] exp);
    @(negedge clk);
    sif.x = xx;
    sif.y = yy;
    exp_q.push_back(exp);
    @(posedge clk);
    @(posedge clk);
    #1;
    pop_chk(tag);
  endtask

  task automatic wr_ctrl(input logic [15:0] c);
    @(negedge clk);
    sif.ctrl_we = 1'b1;
    sif.ctrl_in = c;
    @(negedge clk);
    sif.ctrl_we = 1'b0;
  endtask

  task automatic pulse(input logic wr, input logic [15:0] c);
    @(negedge clk);
    sif.frame_start = 1'b1;
    sif.ctrl_we     = wr;
    sif.ctrl_in     = c;
    @(negedge clk);
    sif.frame_start = 1'b0;
    sif.ctrl_we     = 1'b0;
  endtask

  int exp_loop[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp_one[6]   = '{0, 1, 2, 3, 3, 3};
  int exp_pp[8]    = '{0, 1, 2, 3, 2, 1, 0, 1};
  int done_base;

  initial begin
    reset = 1'b0;
    sif.x = '0; sif.y = '0; sif.x0 = '0; sif.y0 = '0;
    sif.frame_start = 1'b0; sif.we = 1'b0; sif.addr_w = '0; sif.pixel_in = '0;
    sif.ctrl_we = 1'b0; sif.ctrl_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(sif.sprite_rgb), 32'(KEY));
    chk("rst_frame", 32'(sif.cur_frame), 0);
    chk("rst_done", 32'(sif.done), 0);
    reset = 1'b1;
    scan("t1_disabled_key", 0, 0, KEY);
    chk("t1_frame", 32'(sif.cur_frame), 0);

    for (int a = 0; a < (1 << ADDR); a++) begin
      @(negedge clk);
      sif.we = 1'b1;
      sif.addr_w = ADDR'(a);
      sif.pixel_in = pix(ADDR'(a));
      mem[a] = pix(ADDR'(a));
    end
    @(negedge clk);
    sif.we = 1'b0;

    wr_ctrl(16'h0020);
    sif.x0 = 11'd100; sif.y0 = 11'd50;
    pulse(1'b0, 16'h0000);
    scan("t2_pix_r2c3", 103, 52, mem[idx(0, 2, 3)]);
    scan("t2_pix_r63c63", 163, 113, mem[idx(0, 63, 63)]);
    scan("t2_right_edge", 164, 52, KEY);
    scan("t2_above", 103, 49, KEY);

    wr_ctrl(16'h0034);
    sif.x0 = 11'd0; sif.y0 = 11'd0;
    pulse(1'b0, 16'h0000);
    scan("t3_mirror_c61", 5, 0, mem[idx(0, 0, 61)]);
    scan("t3_mirror_c0", 127, 0, mem[idx(0, 0, 0)]);
    scan("t3_scaled_edge", 128, 0, KEY);
    scan("t3_bottom_row", 0, 127, mem[idx(0, 63, 63)]);
    scan("t3_below", 0, 128, KEY);

    @(negedge clk);
    sif.x = 11'd5; sif.y = 11'd0;
    sif.we = 1'b1; sif.addr_w = idx(0, 0, 61); sif.pixel_in = 12'hABC;
    exp_q.push_back(mem[idx(0, 0, 61)]);
    @(negedge clk);
    sif.we = 1'b0;
    mem[idx(0, 0, 61)] = 12'hABC;
    @(posedge clk);
    #1;
    pop_chk("t3_read_first");
    scan("t3_after_write", 5, 0, 12'hABC);

    wr_ctrl(16'h0061);
    pulse(1'b0, 16'h0000);
    chk("t4_apply", 32'(sif.cur_frame), 0);
    for (int i = 0; i < 10; i++) begin
      pulse(1'b0, 16'h0000);
      chk($sformatf("t4_loop_%0d", i), 32'(sif.cur_frame), 32'(exp_loop[i]));
      if (i == 5) scan("t4_frame2_pix", 3, 2, mem[idx(2, 2, 3)]);
    end

    wr_ctrl(16'h0022);
    pulse(1'b0, 16'h0000);
    chk("t5_one_apply", 32'(sif.cur_frame), 0);
    done_base = done_cnt;
    for (int i = 0; i < 6; i++) begin
      pulse(1'b0, 16'h0000);
      chk($sformatf("t5_one_%0d", i), 32'(sif.cur_frame), 32'(exp_one[i]));
      if (i == 3) chk("t5_done_on_last", 32'(sif.done), 1);
    end
    chk("t5_done_once", 32'(done_cnt - done_base), 1);

    wr_ctrl(16'h0023);
    pulse(1'b0, 16'h0000);
    chk("t5_pp_apply", 32'(sif.cur_frame), 0);
    for (int i = 0; i < 8; i++) begin
      pulse(1'b0, 16'h0000);
      chk($sformatf("t5_pp_%0d", i), 32'(sif.cur_frame), 32'(exp_pp[i]));
    end

    pulse(1'b1, 16'h0003);
    chk("t6_old_ctrl", 32'(sif.cur_frame), 2);
    pulse(1'b0, 16'h0000);
    chk("t6_new_ctrl_frozen", 32'(sif.cur_frame), 2);
    scan("t6_disabled_key", 3, 2, KEY);
    pulse(1'b0, 16'h0000);
    chk("t6_still_frozen", 32'(sif.cur_frame), 2);

    wr_ctrl(16'h0023);
    pulse(1'b0, 16'h0000);
    chk("t6_reenabled", 32'(sif.cur_frame), 3);
    scan("t6_frame3_pix", 3, 2, mem[idx(3, 2, 3)]);

    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_rgb", 32'(sif.sprite_rgb), 32'(KEY));
    chk("t6_async_frame", 32'(sif.cur_frame), 0);
    chk("t6_async_done", 32'(sif.done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    scan("t6_post_reset_key", 3, 2, KEY);
    pulse(1'b0, 16'h0000);
    chk("t6_post_reset_frame", 32'(sif.cur_frame), 0);
    scan("t6_post_reset_shadow", 3, 2, KEY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
